// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational fetch lookup, MEM-stage
// resolve updates, sequenced flush and a saturating misprediction counter.
module branch_target_buffer #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      lookup_pc_i,
  output logic             hit_o,
  output logic             pred_taken_o,
  output logic [31:0]      pred_next_pc_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [31:0]      upd_target_i,
  input  logic             upd_mispred_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int ENT = 2 ** IDX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [ENT-1:0]     v_q, v_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Payload is deliberately unreset; V gates every use of it.
  logic [5:0]         tag_q [ENT];
  logic [31:0]        ta_q  [ENT];
  logic               t_q   [ENT];

  logic [IDX_W-1:0]   lk_idx_s, up_idx_s;
  logic [5:0]         lk_tag_s, up_tag_s;
  logic               hit_s, taken_s, up_hit_s, do_upd_s;
  logic               wr_t_s, wr_ta_s, wr_tag_s;
  logic               unused_s;

  assign lk_idx_s = lookup_pc_i[IDX_W+1:2];
  assign lk_tag_s = lookup_pc_i[IDX_W+7:IDX_W+2];
  assign up_idx_s = upd_pc_i[IDX_W+1:2];
  assign up_tag_s = upd_pc_i[IDX_W+7:IDX_W+2];
  assign unused_s = ^{lookup_pc_i[31:IDX_W+8], lookup_pc_i[1:0],
                      upd_pc_i[31:IDX_W+8], upd_pc_i[1:0]};

  // Fetch-side lookup against the pre-edge array contents
  always_comb begin
    hit_s   = v_q[lk_idx_s] & (tag_q[lk_idx_s] == lk_tag_s) & (state_q == IDLE);
    taken_s = hit_s & t_q[lk_idx_s];
    if (taken_s) begin
      pred_next_pc_o = ta_q[lk_idx_s];
    end else begin
      pred_next_pc_o = lookup_pc_i + 32'd4;
    end
  end

  assign hit_o         = hit_s;
  assign pred_taken_o  = taken_s;
  assign busy_o        = (state_q == CLEAR);
  assign mispred_cnt_o = cnt_q;

  // Resolve-side write enables; a flush in IDLE beats a same-cycle update
  always_comb begin
    up_hit_s = v_q[up_idx_s] & (tag_q[up_idx_s] == up_tag_s);
    do_upd_s = (state_q == IDLE) & ~flush_i & upd_valid_i;
    wr_t_s   = do_upd_s & (up_hit_s | upd_taken_i);
    wr_ta_s  = do_upd_s & upd_taken_i;
    wr_tag_s = do_upd_s & ~up_hit_s & upd_taken_i;
  end

  // Flush sequencer and valid-bit next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = CLEAR;
          ptr_d   = {IDX_W{1'b0}};
        end else if (wr_tag_s) begin
          v_d[up_idx_s] = 1'b1;
        end else begin
          v_d = v_q;
        end
      end
      CLEAR: begin
        v_d[ptr_q] = 1'b0;
        if (flush_i) begin
          ptr_d = {IDX_W{1'b0}};
        end else if (ptr_q == {IDX_W{1'b1}}) begin
          state_d = IDLE;
          ptr_d   = {IDX_W{1'b0}};
        end else begin
          ptr_d = ptr_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Saturating misprediction counter, independent of flush state
  always_comb begin
    if (upd_valid_i & upd_mispred_i & ~(&cnt_q)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= {IDX_W{1'b0}};
      v_q     <= {ENT{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry payload storage
  always_ff @(posedge clk) begin
    if (wr_t_s)   t_q[up_idx_s]   <= upd_taken_i;
    if (wr_ta_s)  ta_q[up_idx_s]  <= upd_target_i;
    if (wr_tag_s) tag_q[up_idx_s] <= up_tag_s;
  end

endmodule
